// File: rtl/aes_pkg.sv
// aes_pkg: shared AES word type, round constants, forward S-box and Rcon lookups
package aes_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [3:0] NR = 4'd10;
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [15:0][7:0] RCON = {40'h0, 88'h361b8040201008040201_00};
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[8*(255-int'(b)) +: 8];
    endfunction
    function automatic logic [7:0] rcon(input logic [3:0] r);
        return RCON[r];
    endfunction
endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: forward S-box applied to each byte of a 32-bit word
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] w_in,
    output logic [31:0] w_out
);
    always_comb w_out = {sbox(w_in[31:24]), sbox(w_in[23:16]), sbox(w_in[15:8]), sbox(w_in[7:0])};
endmodule

// File: rtl/key_expand_inv.sv
// key_expand_inv: AES-128 inverse key schedule streaming round keys 10 down to 0
module key_expand_inv
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         last,
    output logic         busy
);
    state_t state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0] idx_q, idx_d;
    word_t w0, w1, w2, w3, sw;
    always_comb begin
        w3 = key_q[31:0] ^ key_q[63:32];
        w2 = key_q[63:32] ^ key_q[95:64];
        w1 = key_q[95:64] ^ key_q[127:96];
        w0 = key_q[127:96] ^ sw ^ {rcon(idx_q), 24'h0};
    end
    aes_sub_word u_sub (.w_in({w3[23:0], w3[31:24]}), .w_out(sw));
    always_comb begin
        state_d = state_q;
        key_d = key_q;
        idx_d = idx_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                key_d = last_key;
                idx_d = NR;
            end
        end else if (key_ready) begin
            if (idx_q == 4'd0) state_d = IDLE;
            else begin
                key_d = {w0, w1, w2, w3};
                idx_d = idx_q - 4'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            key_q <= '0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            key_q <= key_d;
            idx_q <= idx_d;
        end
    end
    always_comb begin
        round_key = key_q;
        round_idx = idx_q;
        key_valid = state_q == RUN;
        busy = state_q == RUN;
        last = (state_q == RUN) && (idx_q == 4'd0);
    end
endmodule

// File: tb/tb_key_expand_inv.sv
// tb_key_expand_inv: directed checks of the inverse key schedule stream
module tb_key_expand_inv;
    logic clk = 1'b0;
    logic reset = 1'b0, start = 1'b0, key_ready = 1'b0;
    logic [127:0] last_key = '0, round_key;
    logic [3:0] round_idx;
    logic key_valid, last, busy;
    logic [127:0] exp_key [0:10];
    logic [7:0] sbox_m [0:255];
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    key_expand_inv dut (
        .clk(clk), .reset(reset), .start(start), .last_key(last_key),
        .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
        .key_ready(key_ready), .last(last), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    task automatic init_model;
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [7:0] rc_m(input int r);
        logic [7:0] x;
        x = 8'h01;
        for (int i = 1; i < r; i++) x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        return x;
    endfunction

    function automatic logic [127:0] inv_step(input logic [127:0] k, input int r);
        logic [31:0] a, b, c, d;
        d = k[31:0] ^ k[63:32];
        c = k[63:32] ^ k[95:64];
        b = k[95:64] ^ k[127:96];
        a = k[127:96] ^ sub_m({d[23:0], d[31:24]}) ^ {rc_m(r), 24'h0};
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input int r);
        logic [31:0] a, b, c, d;
        a = k[127:96] ^ sub_m({k[23:0], k[31:24]}) ^ {rc_m(r), 24'h0};
        b = k[95:64] ^ a;
        c = k[63:32] ^ b;
        d = k[31:0] ^ c;
        return {a, b, c, d};
    endfunction

    task automatic fill_model(input logic [127:0] k);
        exp_key[0] = k;
        for (int i = 1; i <= 10; i++) exp_key[i] = inv_step(exp_key[i-1], 11 - i);
    endtask

    task automatic fill_fips;
        exp_key[0]  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        exp_key[1]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_key[2]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_key[3]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_key[4]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_key[6]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_key[7]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_key[8]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_key[9]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_key[10] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    endtask

    task automatic run_seq(input string tag, input bit rnd, input int start_at, input int reset_at, input bit stall_rst);
        int n, cyc, stl;
        logic [127:0] k;
        k = exp_key[0];
        n = 0;
        cyc = 0;
        stl = 0;
        last_key = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (key_valid && cyc < 100) begin
            if (n > 10) begin
                $display("FAIL %s extra_beat: got beat %0d want at most 11 beats", tag, n + 1);
                n_err++;
                n_cmp++;
                break;
            end
            if (round_key !== exp_key[n]) begin
                $display("FAIL %s key beat%0d: got %h want %h", tag, n, round_key, exp_key[n]);
                n_err++;
            end
            n_cmp++;
            if (round_idx !== 4'(10 - n)) begin
                $display("FAIL %s idx beat%0d: got %0d want %0d", tag, n, round_idx, 10 - n);
                n_err++;
            end
            n_cmp++;
            if (last !== (n == 10) || busy !== 1'b1) begin
                $display("FAIL %s last/busy beat%0d: got %b/%b want %b/1", tag, n, last, busy, n == 10);
                n_err++;
            end
            n_cmp++;
            key_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            start = (int'(round_idx) == start_at);
            last_key = start ? ~k : k;
            if (int'(round_idx) == reset_at) begin
                if (stall_rst) key_ready = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                start = 1'b0;
                if ({key_valid, busy, last, round_idx, round_key} !== '0) begin
                    $display("FAIL %s mid_reset: got v%b b%b l%b idx%0d key %h want all zero", tag, key_valid, busy, last, round_idx, round_key);
                    n_err++;
                end
                n_cmp++;
                return;
            end
            if (key_ready) n++;
            else stl++;
            cyc++;
            tick();
        end
        start = 1'b0;
        last_key = k;
        if (n !== 11 || cyc !== 11 + stl) begin
            $display("FAIL %s beat_count: got %0d beats in %0d cycles want 11 beats in %0d", tag, n, cyc, 11 + stl);
            n_err++;
        end
        n_cmp++;
        if (key_valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 || round_idx !== 4'd0 || round_key !== exp_key[10]) begin
            $display("FAIL %s end_state: got v%b b%b l%b idx%0d key %h want 0 0 0 0 %h", tag, key_valid, busy, last, round_idx, round_key, exp_key[10]);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        last_key = 128'h0123456789abcdef0123456789abcdef;
        tick();
        reset = 1'b0;
        start = 1'b0;
        if ({key_valid, busy, last, round_idx, round_key} !== '0) begin
            $display("FAIL reset_state: got v%b b%b l%b idx%0d key %h want all zero", key_valid, busy, last, round_idx, round_key);
            n_err++;
        end
        n_cmp++;
        tick();
        if (key_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_drops_start: got v%b b%b want 0 0", key_valid, busy);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_fips;
        fill_fips();
        run_seq("fips", 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_backpressure;
        fill_fips();
        run_seq("backpressure", 1'b1, -1, -1, 1'b0);
        key_ready = 1'b0;
        tick();
    endtask

    task automatic test_codebase;
        fill_model(128'h3ea222a7987a5f4a38dc254fec19fc49);
        exp_key[9] = 128'he12186f2c110b4cae152fd9ec119b8c7;
        exp_key[10] = 128'h534f4d452031323820424954204b4559;
        run_seq("codebase", 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        fill_fips();
        run_seq("b2b_first", 1'b0, -1, -1, 1'b0);
        fill_model(128'h3ea222a7987a5f4a38dc254fec19fc49);
        run_seq("b2b_second", 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_start_ignored;
        fill_fips();
        run_seq("start_ignored", 1'b0, 5, -1, 1'b0);
        tick();
        if (key_valid !== 1'b0) begin
            $display("FAIL start_not_queued: got key_valid %b want 0", key_valid);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_mid_reset;
        fill_fips();
        run_seq("reset_stream", 1'b0, -1, 6, 1'b0);
        run_seq("after_reset_stream", 1'b0, -1, -1, 1'b0);
        run_seq("reset_stalled", 1'b0, -1, 6, 1'b1);
        tick();
        run_seq("after_reset_stalled", 1'b1, -1, -1, 1'b0);
    endtask

    task automatic test_zero_key;
        logic [127:0] k;
        fill_model('0);
        run_seq("zero", 1'b0, -1, -1, 1'b0);
        k = round_key;
        for (int r = 1; r <= 10; r++) k = fwd_step(k, r);
        if (k !== '0) begin
            $display("FAIL zero_forward: got key10 %h want 0", k);
            n_err++;
        end
        n_cmp++;
    endtask

    initial begin
        init_model();
        test_reset();
        test_fips();
        test_backpressure();
        test_codebase();
        test_back_to_back();
        test_start_ignored();
        test_mid_reset();
        test_zero_key();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
